// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives IMEM, and queues fetched
// instructions into a 2-entry skid buffer feeding decode over valid/ready.
module if_fetch_unit #(
   parameter int                  PC_WIDTH   = 32,
   parameter int                  INST_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = {PC_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [PC_WIDTH-1:0]   imem_pc,
   input  logic [INST_WIDTH-1:0] imem_inst,
   input  logic                  redirect_valid,
   input  logic [PC_WIDTH-1:0]   redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [PC_WIDTH-1:0]   id_pc,
   output logic [INST_WIDTH-1:0] id_inst,
   output logic                  misalign_err
);

   typedef enum logic [1:0] {
      ST_WARM = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};

   state_e                state_q,    state_d;
   logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
   logic [1:0]            count_q,    count_d;
   logic [PC_WIDTH-1:0]   pc0_q,      pc0_d;
   logic [INST_WIDTH-1:0] inst0_q,    inst0_d;
   logic [PC_WIDTH-1:0]   pc1_q,      pc1_d;
   logic [INST_WIDTH-1:0] inst1_q,    inst1_d;

   logic       push_s;
   logic       pop_s;
   logic       flush_s;
   logic [1:0] wr_idx_s;

   assign imem_pc      = fetch_pc_q;
   assign id_valid     = (count_q != 2'd0);
   assign id_pc        = pc0_q;
   assign id_inst      = inst0_q;
   assign misalign_err = (state_q == ST_HALT);

   // Control: a redirect outranks push and pop; a misaligned target halts with fetch_pc held.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      flush_s    = 1'b0;
      if (redirect_valid) begin
         flush_s = 1'b1;
         if (redirect_pc[1:0] == 2'b00) begin
            fetch_pc_d = redirect_pc;
            state_d    = ST_RUN;
         end else begin
            state_d    = ST_HALT;
         end
      end else begin
         pop_s = id_valid && id_ready;
         case (state_q)
            ST_WARM: begin
               state_d = ST_RUN;
            end
            ST_RUN: begin
               push_s = (count_q != 2'd2) || pop_s;
               if (push_s) begin
                  fetch_pc_d = fetch_pc_q + PC_STEP;
               end else begin
                  fetch_pc_d = fetch_pc_q;
               end
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: begin
               state_d = ST_WARM;
            end
         endcase
      end
   end

   // Skid buffer: entry 0 is always the head, so a pop shifts entry 1 down.
   always_comb begin
      count_d  = count_q;
      pc0_d    = pc0_q;
      inst0_d  = inst0_q;
      pc1_d    = pc1_q;
      inst1_d  = inst1_q;
      wr_idx_s = pop_s ? (count_q - 2'd1) : count_q;
      if (flush_s) begin
         count_d = 2'd0;
      end else begin
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
         if (push_s && (wr_idx_s == 2'd0)) begin
            pc0_d   = fetch_pc_q;
            inst0_d = imem_inst;
         end else if (pop_s) begin
            pc0_d   = pc1_q;
            inst0_d = inst1_q;
         end else begin
            pc0_d   = pc0_q;
            inst0_d = inst0_q;
         end
         if (push_s && (wr_idx_s == 2'd1)) begin
            pc1_d   = fetch_pc_q;
            inst1_d = imem_inst;
         end else begin
            pc1_d   = pc1_q;
            inst1_d = inst1_q;
         end
      end
   end

   // State, PC and buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_WARM;
         fetch_pc_q <= RESET_PC;
         count_q    <= 2'd0;
         pc0_q      <= {PC_WIDTH{1'b0}};
         inst0_q    <= {INST_WIDTH{1'b0}};
         pc1_q      <= {PC_WIDTH{1'b0}};
         inst1_q    <= {INST_WIDTH{1'b0}};
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         pc0_q      <= pc0_d;
         inst0_q    <= inst0_d;
         pc1_q      <= pc1_d;
         inst1_q    <= inst1_d;
      end
   end

endmodule
